// File: rtl/lane_hit_judge.sv
// Per-lane hit/miss judge for four falling-block lanes: synchronises keys,
// detects presses, and tracks score, combo, max combo, misses and game-over.
module lane_hit_judge #(
   parameter logic [9:0] HIT_TOP   = 10'd600,
   parameter logic [9:0] HIT_BOT   = 10'd680,
   parameter logic [9:0] PERF_TOP  = 10'd630,
   parameter logic [9:0] PERF_BOT  = 10'd650,
   parameter logic [9:0] BOTTOM    = 10'd720,
   parameter logic [2:0] MAX_MISS  = 3'd5,
   parameter logic [9:0] SCORE_MAX = 10'd999
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       restart,
   input  logic       stop_or_endgame,
   input  logic [9:0] block_h0,
   input  logic [9:0] block_h1,
   input  logic [9:0] block_h2,
   input  logic [9:0] block_h3,
   input  logic [3:0] key,
   output logic [3:0] hit_pulse,
   output logic [3:0] perfect_pulse,
   output logic [3:0] miss_pulse,
   output logic [9:0] score,
   output logic [6:0] combo,
   output logic [6:0] max_combo,
   output logic [2:0] miss_cnt,
   output logic       game_over
);

   localparam logic [9:0] SPAWN_H = 10'd120;

   logic [9:0] lane_h [4];
   assign lane_h[0] = block_h0;
   assign lane_h[1] = block_h1;
   assign lane_h[2] = block_h2;
   assign lane_h[3] = block_h3;

   logic [3:0] sync1_q, sync2_q, key_prev_q;
   logic [3:0] press;
   logic [3:0] hit_ev, perf_ev, miss_ev, bad_ev;
   logic       active;

   logic [3:0] hit_q, perf_q, miss_q;
   logic [9:0] score_q, score_d;
   logic [6:0] combo_q, combo_d;
   logic [6:0] max_combo_q, max_combo_d;
   logic [2:0] miss_cnt_q, miss_cnt_d;
   logic       game_over_q, game_over_d;

   // Edges are consumed every cycle, so a press made while frozen never replays.
   assign press  = sync2_q & ~key_prev_q;
   assign active = !stop_or_endgame && !game_over_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         key_prev_q <= '0;
      end else if (restart) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         key_prev_q <= '0;
      end else begin
         sync1_q    <= key;
         sync2_q    <= sync1_q;
         key_prev_q <= sync2_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [9:0] prev_h_q, prev_h_d;
         logic       judged_q, judged_d;
         logic       rearm, in_win, in_perf;

         assign in_win  = (lane_h[gi] >= HIT_TOP) && (lane_h[gi] <= HIT_BOT);
         assign in_perf = (lane_h[gi] >= PERF_TOP) && (lane_h[gi] <= PERF_BOT);
         // A height drop means a fresh block spawned; that cycle is never judged.
         assign rearm   = active && (lane_h[gi] < prev_h_q);

         assign hit_ev[gi]  = active && press[gi] && !judged_q && !rearm && in_win;
         assign perf_ev[gi] = hit_ev[gi] && in_perf;
         assign miss_ev[gi] = active && !judged_q && !rearm && (lane_h[gi] >= BOTTOM);
         assign bad_ev[gi]  = active && press[gi] && !hit_ev[gi];

         always_comb begin
            judged_d = judged_q;
            prev_h_d = prev_h_q;
            if (active) begin
               prev_h_d = lane_h[gi];
               if (rearm)
                  judged_d = 1'b0;
               else if (hit_ev[gi] || miss_ev[gi])
                  judged_d = 1'b1;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               prev_h_q <= SPAWN_H;
               judged_q <= 1'b0;
            end else if (restart) begin
               prev_h_q <= SPAWN_H;
               judged_q <= 1'b0;
            end else begin
               prev_h_q <= prev_h_d;
               judged_q <= judged_d;
            end
         end
      end
   endgenerate

   logic [3:0]  add;
   logic [2:0]  n_hits, n_miss;
   logic [10:0] score_sum;
   logic [7:0]  combo_sum;
   logic [3:0]  miss_sum;

   always_comb begin
      add    = '0;
      n_hits = '0;
      n_miss = '0;
      for (int i = 0; i < 4; i++) begin
         if (hit_ev[i]) begin
            add    = add + (perf_ev[i] ? 4'd2 : 4'd1);
            n_hits = n_hits + 3'd1;
         end
         if (miss_ev[i])
            n_miss = n_miss + 3'd1;
      end
      score_sum = {1'b0, score_q} + {7'b0, add};
      combo_sum = {1'b0, combo_q} + {5'b0, n_hits};
      miss_sum  = {1'b0, miss_cnt_q} + {1'b0, n_miss};

      score_d     = score_q;
      combo_d     = combo_q;
      miss_cnt_d  = miss_cnt_q;
      max_combo_d = max_combo_q;
      game_over_d = game_over_q;
      if (active) begin
         score_d    = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];
         miss_cnt_d = miss_sum[3] ? 3'd7 : miss_sum[2:0];
         if ((|miss_ev) || (|bad_ev))
            combo_d = '0;
         else
            combo_d = combo_sum[7] ? 7'd127 : combo_sum[6:0];
         if (combo_d > max_combo_q)
            max_combo_d = combo_d;
         if (miss_cnt_d >= MAX_MISS)
            game_over_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_q       <= '0;
         perf_q      <= '0;
         miss_q      <= '0;
         score_q     <= '0;
         combo_q     <= '0;
         max_combo_q <= '0;
         miss_cnt_q  <= '0;
         game_over_q <= 1'b0;
      end else if (restart) begin
         hit_q       <= '0;
         perf_q      <= '0;
         miss_q      <= '0;
         score_q     <= '0;
         combo_q     <= '0;
         max_combo_q <= '0;
         miss_cnt_q  <= '0;
         game_over_q <= 1'b0;
      end else begin
         hit_q       <= hit_ev;
         perf_q      <= perf_ev;
         miss_q      <= miss_ev;
         score_q     <= score_d;
         combo_q     <= combo_d;
         max_combo_q <= max_combo_d;
         miss_cnt_q  <= miss_cnt_d;
         game_over_q <= game_over_d;
      end
   end

   assign hit_pulse     = hit_q;
   assign perfect_pulse = perf_q;
   assign miss_pulse    = miss_q;
   assign score         = score_q;
   assign combo         = combo_q;
   assign max_combo     = max_combo_q;
   assign miss_cnt      = miss_cnt_q;
   assign game_over     = game_over_q;

endmodule
